// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer in front of the 1024x32 data memory.
// Ports: clk, rst_n (async active-low); pN_req/we/loadb/addr/wdata in,
//   pN_gnt/ack/rdata out (N = 0 CPU MEM stage, 1 debug/DMA loader);
//   dm_addr/din/we/loadb/byte out to the memory, dm_dout in from it.
// Optional macro DM_ARB_STATS_EN adds stats_clr in, p0_cnt/p1_cnt out
//   (saturating per-port completed-access counters).
module dm_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int RR_INIT  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic [1:0]  p0_we,
    input  logic        p0_loadb,
    input  logic [11:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [1:0]  p1_we,
    input  logic        p1_loadb,
    input  logic [11:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic [9:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic [1:0]  dm_we,
    output logic        dm_loadb,
    output logic [1:0]  dm_byte,
    input  logic [31:0] dm_dout
`ifdef DM_ARB_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] p0_cnt,
    output logic [15:0] p1_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e      state_q;
    logic        ptr_q;
    logic        win_q;
    logic        p0_gnt_q, p1_gnt_q;
    logic        p0_ack_q, p1_ack_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;
    logic [9:0]  dm_addr_q;
    logic [31:0] dm_din_q;
    logic [1:0]  dm_we_q;
    logic        dm_loadb_q;
    logic [1:0]  dm_byte_q;

    logic        pick_d;
    logic [1:0]  sel_we;
    logic        sel_loadb;
    logic [11:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  we_d;
    logic        loadb_d;

    // Winner selection; only meaningful while at least one req is high.
    always_comb begin
        pick_d = 1'b0;
        if (p0_req && p1_req) begin
            pick_d = (ARB_MODE == 1) ? 1'b0 : ptr_q;
        end else if (p1_req) begin
            pick_d = 1'b1;
        end
    end

    always_comb begin
        sel_we    = pick_d ? p1_we    : p0_we;
        sel_loadb = pick_d ? p1_loadb : p0_loadb;
        sel_addr  = pick_d ? p1_addr  : p0_addr;
        sel_wdata = pick_d ? p1_wdata : p0_wdata;
        // Reserved encoding 11 degrades to a read.
        we_d      = (sel_we == 2'b11) ? 2'b00 : sel_we;
        // Load-byte only makes sense for reads.
        loadb_d   = sel_loadb && (we_d == 2'b00);
    end

    // The dm_* registers double as the latched command; dm_we is the
    // only one cleared outside ACCESS, and reset clears it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= (RR_INIT != 0);
            win_q      <= 1'b0;
            p0_gnt_q   <= 1'b0;
            p1_gnt_q   <= 1'b0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_rdata_q <= 32'd0;
            p1_rdata_q <= 32'd0;
            dm_addr_q  <= 10'd0;
            dm_din_q   <= 32'd0;
            dm_we_q    <= 2'b00;
            dm_loadb_q <= 1'b0;
            dm_byte_q  <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        win_q      <= pick_d;
                        p0_gnt_q   <= ~pick_d;
                        p1_gnt_q   <= pick_d;
                        dm_addr_q  <= sel_addr[11:2];
                        dm_byte_q  <= sel_addr[1:0];
                        dm_din_q   <= sel_wdata;
                        dm_we_q    <= we_d;
                        dm_loadb_q <= loadb_d;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    dm_we_q <= 2'b00;
                    if (win_q) begin
                        p1_rdata_q <= dm_dout;
                        p1_ack_q   <= 1'b1;
                    end else begin
                        p0_rdata_q <= dm_dout;
                        p0_ack_q   <= 1'b1;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    p0_gnt_q <= 1'b0;
                    p1_gnt_q <= 1'b0;
                    if (ARB_MODE == 0) begin
                        ptr_q <= ~ptr_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p0_gnt   = p0_gnt_q;
    assign p1_gnt   = p1_gnt_q;
    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign dm_addr  = dm_addr_q;
    assign dm_din   = dm_din_q;
    assign dm_we    = dm_we_q;
    assign dm_loadb = dm_loadb_q;
    assign dm_byte  = dm_byte_q;

`ifdef DM_ARB_STATS_EN
    logic [15:0] p0_cnt_q, p1_cnt_q;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_cnt_q <= 16'd0;
            p1_cnt_q <= 16'd0;
        end else if (stats_clr) begin
            p0_cnt_q <= 16'd0;
            p1_cnt_q <= 16'd0;
        end else begin
            if (p0_ack_q && (p0_cnt_q != 16'hFFFF)) begin
                p0_cnt_q <= p0_cnt_q + 16'd1;
            end
            if (p1_ack_q && (p1_cnt_q != 16'hFFFF)) begin
                p1_cnt_q <= p1_cnt_q + 16'd1;
            end
        end
    end

    assign p0_cnt = p0_cnt_q;
    assign p1_cnt = p1_cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a 1024x32 memory model.
// Instance u_rr runs round-robin, u_fp fixed priority, on shared stimulus.
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [1:0]  p0_we = 2'b00, p1_we = 2'b00;
    logic        p0_loadb = 1'b0, p1_loadb = 1'b0;
    logic [11:0] p0_addr = 12'd0, p1_addr = 12'd0;
    logic [31:0] p0_wdata = 32'd0, p1_wdata = 32'd0;

    logic        p0_gnt, p1_gnt, p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;
    logic [1:0]  dm_we, dm_byte;
    logic        dm_loadb;

    logic        f0_gnt, f1_gnt, f0_ack, f1_ack;
    logic [31:0] f0_rdata, f1_rdata;
    logic [9:0]  f_addr;
    logic [31:0] f_din;
    logic [1:0]  f_we, f_byte;
    logic        f_loadb;
    logic [31:0] f_dout;
    assign f_dout = 32'd0;

`ifdef DM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] p0_cnt, p1_cnt, f0_cnt, f1_cnt;
`endif

    dm_arbiter #(.ARB_MODE(0), .RR_INIT(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_loadb(p0_loadb),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_loadb(p1_loadb),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_loadb(dm_loadb), .dm_byte(dm_byte), .dm_dout(dm_dout)
`ifdef DM_ARB_STATS_EN
        , .stats_clr(stats_clr), .p0_cnt(p0_cnt), .p1_cnt(p1_cnt)
`endif
    );

    dm_arbiter #(.ARB_MODE(1), .RR_INIT(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_loadb(p0_loadb),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(f0_gnt), .p0_ack(f0_ack), .p0_rdata(f0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_loadb(p1_loadb),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(f1_gnt), .p1_ack(f1_ack), .p1_rdata(f1_rdata),
        .dm_addr(f_addr), .dm_din(f_din), .dm_we(f_we),
        .dm_loadb(f_loadb), .dm_byte(f_byte), .dm_dout(f_dout)
`ifdef DM_ARB_STATS_EN
        , .stats_clr(stats_clr), .p0_cnt(f0_cnt), .p1_cnt(f1_cnt)
`endif
    );

    // Memory model: word/byte-lane write, combinational sign-extending read.
    logic [31:0] mem [1024] = '{default: 32'd0};
    logic [31:0] mword;
    logic [7:0]  mbyte;

    always @(posedge clk) begin
        if (dm_we == 2'b01) mem[dm_addr] <= dm_din;
        else if (dm_we == 2'b10) mem[dm_addr][dm_byte*8 +: 8] <= dm_din[7:0];
    end

    always_comb begin
        mword   = mem[dm_addr];
        mbyte   = mword[dm_byte*8 +: 8];
        dm_dout = dm_loadb ? {{24{mbyte[7]}}, mbyte} : mword;
    end

    int we01_cyc = 0;
    int wnz_cyc = 0;
    int ld_cyc = 0;
    always @(negedge clk) begin
        if (dm_we == 2'b01) we01_cyc++;
        if (dm_we != 2'b00) wnz_cyc++;
        if (dm_loadb) ld_cyc++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on u_rr; lat counts clock edges from grant sampling to ack.
    task automatic acc(input bit port, input logic [1:0] we,
                       input logic ld, input logic [11:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output int lat);
        bit got;
        @(negedge clk);
        if (port) begin
            p1_we = we; p1_loadb = ld; p1_addr = a; p1_wdata = wd; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_loadb = ld; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = port ? p1_ack : p0_ack;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        chk("gnt_at_ack", {31'd0, port ? p1_gnt : p0_gnt}, 32'd1);
        rd = port ? p1_rdata : p0_rdata;
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    logic [31:0] rd;
    int lat, w0, n0, l0;
    int ack_port[4];
    int ack_cyc[4];
    int nack, p0n, p1n, drop_cyc;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_gnt_ack", {28'd0, p1_gnt, p0_gnt, p1_ack, p0_ack}, 32'd0);
        chk("rst_dm_ctl", {27'd0, dm_we, dm_loadb, dm_byte}, 32'd0);
        chk("rst_dm_addr", {22'd0, dm_addr}, 32'd0);
        chk("rst_dm_din", dm_din, 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word write then read.
        w0 = we01_cyc;
        acc(1'b0, 2'b01, 1'b0, 12'h010, 32'hDEADBEEF, rd, lat);
        chk("wr_lat", lat, 2);
        chk("wr_we_cycles", we01_cyc - w0, 1);
        acc(1'b0, 2'b00, 1'b0, 12'h010, 32'd0, rd, lat);
        chk("rd_lat", lat, 2);
        chk("rd_word", rd, 32'hDEADBEEF);

        // Byte write, sign-extended byte read, word read.
        acc(1'b1, 2'b10, 1'b0, 12'h022, 32'hAAAAAA80, rd, lat);
        acc(1'b1, 2'b00, 1'b1, 12'h022, 32'd0, rd, lat);
        chk("rd_sext_byte", rd, 32'hFFFFFF80);
        acc(1'b1, 2'b00, 1'b0, 12'h020, 32'd0, rd, lat);
        chk("rd_word_020", rd, 32'h00800000);
        chk("loser_keeps", p0_rdata, 32'hDEADBEEF);

        // Unaligned word access, reserved we, loadb on a write.
        acc(1'b0, 2'b00, 1'b0, 12'h013, 32'd0, rd, lat);
        chk("rd_unaligned", rd, 32'hDEADBEEF);
        n0 = wnz_cyc;
        acc(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, rd, lat);
        chk("we11_no_write", wnz_cyc - n0, 0);
        chk("we11_reads", rd, 32'hDEADBEEF);
        l0 = ld_cyc;
        acc(1'b0, 2'b01, 1'b1, 12'h031, 32'h11223344, rd, lat);
        chk("wr_loadb_forced0", ld_cyc - l0, 0);
        acc(1'b1, 2'b00, 1'b0, 12'h030, 32'd0, rd, lat);
        chk("wr_unaligned_word", rd, 32'h11223344);

        // Round-robin contention from a fresh pointer.
        rst_pulse();
        @(negedge clk);
        p0_we = 2'b00; p0_loadb = 1'b0; p0_addr = 12'h010;
        p1_we = 2'b00; p1_loadb = 1'b0; p1_addr = 12'h020;
        p0_req = 1'b1; p1_req = 1'b1;
        nack = 0;
        for (int c = 1; c <= 40 && nack < 4; c++) begin
            @(negedge clk);
            if (p0_ack && p1_ack) chk("rr_dual_ack", 32'd1, 32'd0);
            if (p0_ack || p1_ack) begin
                ack_port[nack] = p1_ack ? 1 : 0;
                ack_cyc[nack] = c;
                nack++;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("rr_nack", nack, 4);
        chk("rr_first_lat", ack_cyc[0], 2);
        for (int k = 0; k < 4; k++) begin
            chk("rr_order", ack_port[k], k % 2);
            if (k > 0) chk("rr_gap", ack_cyc[k] - ack_cyc[k-1], 3);
        end

        // Fixed priority on u_fp.
        rst_pulse();
        @(negedge clk);
        p0_req = 1'b1; p1_req = 1'b1;
        p0n = 0; p1n = 0; drop_cyc = 0;
        for (int c = 1; c <= 40 && p1n == 0; c++) begin
            @(negedge clk);
            if (f0_ack) begin
                p0n++;
                if (p0n == 3) begin
                    p0_req = 1'b0;
                    drop_cyc = c;
                end
            end
            if (f1_ack) begin
                p1n++;
                chk("fp_p0_done_first", p0n, 3);
                chk("fp_p1_after_drop", c - drop_cyc, 3);
                p1_req = 1'b0;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("fp_p0_acks", p0n, 3);
        chk("fp_p1_acks", p1n, 1);

        // Reset during the ACCESS cycle of a write.
        rst_pulse();
        @(negedge clk);
        p0_we = 2'b01; p0_loadb = 1'b0;
        p0_addr = 12'h040; p0_wdata = 32'h12345678; p0_req = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_rst_we", {30'd0, dm_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", {30'd0, dm_we}, 32'd0);
        chk("mid_rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
        chk("mid_rst_dm", {dm_addr, dm_loadb, dm_byte} | dm_din, 32'd0);
        p0_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdata", p0_rdata | p1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acc(1'b0, 2'b00, 1'b0, 12'h040, 32'd0, rd, lat);
        chk("no_partial_write", rd, 32'd0);

`ifdef DM_ARB_STATS_EN
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        for (int k = 0; k < 5; k++)
            acc(1'b0, 2'b00, 1'b0, 12'h010, 32'd0, rd, lat);
        for (int k = 0; k < 2; k++)
            acc(1'b1, 2'b00, 1'b0, 12'h020, 32'd0, rd, lat);
        @(negedge clk);
        chk("stats_p0", {16'd0, p0_cnt}, 32'd5);
        chk("stats_p1", {16'd0, p1_cnt}, 32'd2);
        acc(1'b0, 2'b00, 1'b0, 12'h010, 32'd0, rd, lat);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("stats_clr_prio", {p1_cnt, p0_cnt}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
